axi4lite_cmd_master: RTL

AXI4LITE_CMD_MASTER -- requirements
Module: axi4lite_cmd_master

---
 rtl/axi4lite_cmd_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI write or
// read burst-free transaction and returns a single held response.
module axi4lite_cmd_master #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [3:0]    cmd_wstrb,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic [1:0]    rsp_resp,
    output logic [7:0]    err_cnt,
    output logic [AW-1:0] AWADDR,
    output logic          AWVALID,
    input  logic          AWREADY,
    output logic [DW-1:0] WDATA,
    output logic [3:0]    WSTRB,
    output logic          WVALID,
    input  logic          WREADY,
    input  logic [1:0]    BRESP,
    input  logic          BVALID,
    output logic          BREADY,
    output logic [AW-1:0] ARADDR,
    output logic          ARVALID,
    input  logic          ARREADY,
    input  logic [DW-1:0] RDATA,
    input  logic [1:0]    RRESP,
    input  logic          RVALID,
    output logic          RREADY
);

    typedef enum logic [2:0] {IDLE, WR, WB, RD, RDAT, RSP} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_awaddr;
    logic          r_awvalid;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_wvalid;
    logic          r_bready;
    logic [AW-1:0] r_araddr;
    logic          r_arvalid;
    logic          r_rready;
    logic          r_rsp_valid;
    logic          r_rsp_we;
    logic [DW-1:0] r_rsp_rdata;
    logic [1:0]    r_rsp_resp;
    logic [7:0]    r_err_cnt;

    logic          w_accept;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_wr_done;
    logic          w_b_hs;
    logic          w_ar_hs;
    logic          w_r_hs;
    logic          w_rsp_hs;
    logic          w_capture;
    logic [1:0]    w_cap_resp;

    assign cmd_ready  = (r_state == IDLE);
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_aw_hs    = r_awvalid & AWREADY;
    assign w_w_hs     = r_wvalid & WREADY;
    // A channel whose VALID is already low has finished its handshake earlier.
    assign w_wr_done  = (~r_awvalid | w_aw_hs) & (~r_wvalid | w_w_hs);
    assign w_b_hs     = r_bready & BVALID;
    assign w_ar_hs    = r_arvalid & ARREADY;
    assign w_r_hs     = r_rready & RVALID;
    assign w_rsp_hs   = r_rsp_valid & rsp_ready;
    assign w_capture  = w_b_hs | w_r_hs;
    assign w_cap_resp = w_b_hs ? BRESP : RRESP;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (cmd_valid) w_state_next = cmd_we ? WR : RD;
            WR:   if (w_wr_done) w_state_next = WB;
            WB:   if (w_b_hs)    w_state_next = RSP;
            RD:   if (w_ar_hs)   w_state_next = RDAT;
            RDAT: if (w_r_hs)    w_state_next = RSP;
            RSP:  if (w_rsp_hs)  w_state_next = IDLE;
            default:             w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_accept) begin
                if (cmd_we) begin
                    r_awaddr  <= cmd_addr;
                    r_wdata   <= cmd_wdata;
                    r_wstrb   <= cmd_wstrb;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                end else begin
                    r_araddr  <= cmd_addr;
                    r_arvalid <= 1'b1;
                end
            end
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
            if (r_state == WR && w_wr_done) r_bready <= 1'b1;
            if (w_b_hs)  r_bready  <= 1'b0;
            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b1;
            end
            if (w_r_hs)  r_rready  <= 1'b0;
            // Response fields are only loaded here, so they hold through RSP.
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_we    <= w_b_hs;
                r_rsp_rdata <= w_b_hs ? '0 : RDATA;
                r_rsp_resp  <= w_cap_resp;
                if (w_cap_resp != 2'b00 && r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            if (w_rsp_hs) r_rsp_valid <= 1'b0;
        end
    end

    assign AWADDR    = r_awaddr;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_bready;
    assign ARADDR    = r_araddr;
    assign ARVALID   = r_arvalid;
    assign RREADY    = r_rready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_we    = r_rsp_we;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign err_cnt   = r_err_cnt;

endmodule
